wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Wishbone classic single-transfer initiator that turns commands from a valid/ready interface into Wishbone bus cycles and returns the result on a valid/ready response interface. It drives peripheral responders such as the LED bar graph slave and the SDRAM control registers from internal logic, such as a test sequencer or a UART bridge, with no soft CPU. Only one transfer is ever outstanding, and an optional watchdog aborts cycles that are never acknowledged.

## Interface
Parameters:
- ADDR_WIDTH, 1: width of the command address and of wbm_address.
- DATA_WIDTH, 16: width of all data buses.
- TIMEOUT_CYCLES, 255: number of unacknowledged bus cycles before an abort. Used only with WB_MASTER_TIMEOUT_EN. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_WIDTH  target address.
- cmd_writedata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_readdata  out  DATA_WIDTH  read data. 0 for writes and for aborts.
- rsp_error  out  1  transfer aborted by timeout.
- wbm_address  out  ADDR_WIDTH  Wishbone address.
- wbm_writedata  out  DATA_WIDTH  Wishbone write data.
- wbm_readdata  in  DATA_WIDTH  Wishbone read data.
- wbm_strobe  out  1  Wishbone STB.
- wbm_write  out  1  Wishbone WE.
- wbm_cycle  out  1  Wishbone CYC.
- wbm_ack  in  1  Wishbone ACK.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- IDLE
  - cmd_ready = 1.
  - When cmd_valid is high, the command is accepted: address, data and write flag are latched, and the next state is BUS.
- BUS
  - wbm_cycle = wbm_strobe = 1.
  - wbm_address, wbm_writedata and wbm_write come from the latched registers and stay stable for the whole cycle.
  - When wbm_ack is sampled high:
    - capture rsp_readdata = wbm_readdata on a read, or 0 on a write;
    - set rsp_error = 0;
    - deassert cycle and strobe on the same edge;
    - go to RESP.
- RESP
  - rsp_valid = 1, with rsp_readdata and rsp_error held.
  - When rsp_ready is high, go to IDLE.
- cmd_ready is 0 in BUS and RESP, so exactly one transfer is outstanding.
- wbm_ack is ignored outside BUS. A stray ack has no effect.
- wbm_write is 0 whenever wbm_cycle is 0.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Timing
- Reset values:
  - state = IDLE, so cmd_ready = 1;
  - rsp_valid, rsp_error, wbm_cycle, wbm_strobe, wbm_write and busy = 0;
  - rsp_readdata, wbm_address and wbm_writedata = 0.
- The command is accepted at edge N. wbm_cycle and wbm_strobe are high from the cycle after edge N.
- With ack in the first bus cycle:
  - ack is sampled at edge N+1;
  - rsp_valid is high after edge N+1;
  - the minimum command-to-response latency is 2 cycles.
- A back-to-back throughput with rsp_ready held high is one transfer per 3 cycles (IDLE, BUS, RESP).
- Wait states: each cycle with wbm_ack low extends BUS by one cycle, with all outputs held.
- Reset during BUS or RESP takes effect at the next edge:
  - cycle and strobe drop;
  - the pending transfer is discarded;
  - no response is issued.
- cmd_valid and reset high together: reset wins, and the command is not accepted.

## Configuration
- WB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, the next edge drops cycle and strobe, sets rsp_error = 1 and rsp_readdata = 0, and goes to RESP.
  - An ack arriving in the same cycle as the terminal count wins, and the transfer completes normally.
- WB_MASTER_TIMEOUT_EN undefined:
  - There is no counter, and BUS waits indefinitely for ack.
  - rsp_error is constant 0.

## Test plan
- Write, zero-wait slave:
  - Stimulus: cmd write, addr 0, data 16'h00A5, responder acks in the first bus cycle.
  - Response: one bus cycle with wbm_write = 1 and wbm_writedata = 16'h00A5; rsp_valid high 2 cycles after acceptance; rsp_error = 0; rsp_readdata = 0.
- Read with 3 wait states:
  - Stimulus: cmd read, addr 1, slave returns 16'h1234 with ack on the 4th bus cycle.
  - Response: cycle and strobe high for exactly 4 cycles with the address stable; rsp_readdata = 16'h1234.
- Response backpressure:
  - Stimulus: rsp_ready held low 5 cycles after the transfer; cmd_valid high throughout.
  - Response: rsp_valid and rsp_readdata held; cmd_ready = 0 until the cycle after the rsp handshake.
- Timeout:
  - Stimulus: WB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, responder never acks.
  - Response: cycle drops after 8 bus cycles; rsp_error = 1; rsp_readdata = 0. A following command completes normally.
- Reset mid-cycle:
  - Stimulus: reset asserted for 1 cycle during BUS.
  - Response: cycle and strobe low at the next edge; no rsp_valid; cmd_ready = 1 after reset.
- Stray ack:
  - Stimulus: wbm_ack pulsed in IDLE.
  - Response: no state change and no rsp_valid.

Source files
------------

// File: rtl/wb_cmd_master.sv
// ----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-transfer initiator. It takes one command from a
// valid/ready command port and runs it as a Wishbone bus cycle. The result is
// returned on a valid/ready response port. Only one transfer is ever in
// flight: IDLE accepts a command, BUS runs the Wishbone cycle, and RESP holds
// the response until it is consumed.
//
// Optional feature (compile-time macro WB_MASTER_TIMEOUT_EN):
//   When defined, a watchdog aborts a bus cycle that has gone TIMEOUT_CYCLES
//   cycles without wbm_ack. The abort returns rsp_error = 1 and
//   rsp_readdata = 0. When undefined, BUS waits for ack indefinitely and
//   rsp_error is constant 0.
//
// Parameters:
//   ADDR_WIDTH      width of cmd_address / wbm_address
//   DATA_WIDTH      width of all data buses
//   TIMEOUT_CYCLES  unacknowledged bus cycles before an abort (>= 1),
//                   used only with WB_MASTER_TIMEOUT_EN
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready          command handshake
//   cmd_write, cmd_address,
//   cmd_writedata                  command payload (1 = write, 0 = read)
//   rsp_valid / rsp_ready          response handshake
//   rsp_readdata, rsp_error        response payload (readdata 0 on writes/aborts)
//   wbm_*                          Wishbone classic initiator signals
//   busy                           high whenever the FSM is not in IDLE
//
// All outputs come from flops or are decoded from the state register only, so
// there is no combinational path from any input to any output.
// ----------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 1,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_writedata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_readdata,
    output logic                  rsp_error,

    output logic [ADDR_WIDTH-1:0] wbm_address,
    output logic [DATA_WIDTH-1:0] wbm_writedata,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_strobe,
    output logic                  wbm_write,
    output logic                  wbm_cycle,
    input  logic                  wbm_ack,

    output logic                  busy
);

    // A zero timeout would abort before the responder could ever answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic                    we_q,     we_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic                    err_q,    err_d;

    // Terminal-count flag: high in the last BUS cycle the watchdog allows.
    logic                    timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    // Counts completed BUS cycles without ack; cleared on entry to BUS.
    // It never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]        cnt_q,    cnt_d;

    // cnt_q == TIMEOUT_CYCLES-1 means this is bus cycle number TIMEOUT_CYCLES,
    // so the abort edge closes exactly TIMEOUT_CYCLES bus cycles.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    we_d    = cmd_write;
                    state_d = ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            ST_BUS: begin
                // Ack takes priority over the watchdog when both land in
                // the same cycle, so a late but valid answer is not lost.
                if (wbm_ack) begin
                    rdata_d = we_q ? '0 : wbm_readdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Reset clears everything, so a transfer
    // caught mid-flight is dropped without a response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: state decodes and register copies only.
    // ------------------------------------------------------------------
    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_readdata  = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    assign rsp_error     = err_q;
`else
    assign rsp_error     = 1'b0;
`endif

    assign wbm_cycle     = (state_q == ST_BUS);
    assign wbm_strobe    = (state_q == ST_BUS);
    // The latched write flag lingers after the cycle; gate it so WE is never
    // seen high outside a bus cycle.
    assign wbm_write     = (state_q == ST_BUS) && we_q;
    assign wbm_address   = addr_q;
    assign wbm_writedata = wdata_q;

`ifndef WB_MASTER_TIMEOUT_EN
    // err_q only ever gets set by the watchdog; without it the flop is
    // constant and left unread.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Self-checking bench for wb_cmd_master. A table of transfers is applied in a
// loop; expected responses go into a scoreboard queue when a command is
// accepted and are popped when the response handshake happens. Hand-written
// sequences cover reset mid-cycle, reset with cmd_valid, and a stray ack.
// With WB_MASTER_TIMEOUT_EN defined, a never-acked transfer is added to the
// table.
// ----------------------------------------------------------------------------
module tb_wb_cmd_master;

    localparam int AW = 1;
    localparam int DW = 16;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 255;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_writedata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_readdata;
    logic          rsp_error;
    logic [AW-1:0] wbm_address;
    logic [DW-1:0] wbm_writedata;
    logic [DW-1:0] wbm_readdata;
    logic          wbm_strobe;
    logic          wbm_write;
    logic          wbm_cycle;
    logic          wbm_ack;
    logic          busy;

    wb_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_address   (cmd_address),
        .cmd_writedata (cmd_writedata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_readdata  (rsp_readdata),
        .rsp_error     (rsp_error),
        .wbm_address   (wbm_address),
        .wbm_writedata (wbm_writedata),
        .wbm_readdata  (wbm_readdata),
        .wbm_strobe    (wbm_strobe),
        .wbm_write     (wbm_write),
        .wbm_cycle     (wbm_cycle),
        .wbm_ack       (wbm_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] slave_rdata;  // what the responder drives with ack
        int            ack_at;       // bus cycle that carries ack, 0 = never
        int            hold;         // cycles rsp_ready is held low
        logic          keep_valid;   // keep cmd_valid high during the transfer
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_xfer(input vec_t v);
        int   bus_cyc;
        int   exp_cyc;
        rsp_t exp_r;

        exp_cyc = (v.ack_at != 0) ? v.ack_at : TO_CYC;
        chk({v.name, "/idle_ready"}, 32'(cmd_ready), 32'd1);

        cmd_valid     = 1'b1;
        cmd_write     = v.write;
        cmd_address   = v.addr;
        cmd_writedata = v.wdata;
        tick();
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});

        // Scramble the command inputs so the bus must use the latched copy.
        cmd_valid     = v.keep_valid;
        cmd_write     = ~v.write;
        cmd_address   = ~v.addr;
        cmd_writedata = ~v.wdata;

        bus_cyc = 0;
        while (wbm_cycle === 1'b1 && bus_cyc < 64) begin
            bus_cyc++;
            chk({v.name, "/stb"},   32'(wbm_strobe),  32'd1);
            chk({v.name, "/addr"},  32'(wbm_address), 32'(v.addr));
            chk({v.name, "/we"},    32'(wbm_write),   32'(v.write));
            if (v.write) chk({v.name, "/wdata"}, 32'(wbm_writedata), 32'(v.wdata));
            chk({v.name, "/bus_ready"}, 32'(cmd_ready), 32'd0);
            chk({v.name, "/bus_rspv"},  32'(rsp_valid), 32'd0);
            chk({v.name, "/bus_busy"},  32'(busy),      32'd1);
            if (v.ack_at != 0 && bus_cyc == v.ack_at) begin
                wbm_ack      = 1'b1;
                wbm_readdata = v.slave_rdata;
            end
            tick();
            wbm_ack      = 1'b0;
            wbm_readdata = DW'($urandom);
        end
        chk({v.name, "/bus_cycles"}, 32'(bus_cyc), 32'(exp_cyc));
        chk({v.name, "/end_cyc"},   32'(wbm_cycle),  32'd0);
        chk({v.name, "/end_stb"},   32'(wbm_strobe), 32'd0);
        chk({v.name, "/end_we"},    32'(wbm_write),  32'd0);
        chk({v.name, "/rsp_valid"}, 32'(rsp_valid),  32'd1);

        for (int i = 0; i < v.hold; i++) begin
            chk({v.name, "/hold_valid"}, 32'(rsp_valid),    32'd1);
            chk({v.name, "/hold_data"},  32'(rsp_readdata), 32'(v.exp_rdata));
            chk({v.name, "/hold_ready"}, 32'(cmd_ready),    32'd0);
            tick();
        end

        // Handshake happens on the next edge; compare against the scoreboard.
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            chk({v.name, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_r = sb_q.pop_front();
            chk({v.name, "/rsp_data"},  32'(rsp_readdata), 32'(exp_r.rdata));
            chk({v.name, "/rsp_error"}, 32'(rsp_error),    32'(exp_r.err));
            chk({v.name, "/hs_ready"},  32'(cmd_ready),    32'd0);
        end
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({v.name, "/post_ready"}, 32'(cmd_ready), 32'd1);
        chk({v.name, "/post_rspv"},  32'(rsp_valid), 32'd0);
        chk({v.name, "/post_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        vecs.push_back('{"wr_zero_wait", 1'b1, 1'b0, 16'h00A5, 16'h7777, 1, 0, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{"rd_3_wait",    1'b0, 1'b1, 16'h0000, 16'h1234, 4, 0, 1'b0, 16'h1234, 1'b0});
        vecs.push_back('{"rd_backpress", 1'b0, 1'b0, 16'h0F0F, 16'hBEEF, 1, 5, 1'b1, 16'hBEEF, 1'b0});
        vecs.push_back('{"wr_1_wait",    1'b1, 1'b1, 16'hFFFF, 16'h5A5A, 2, 0, 1'b0, 16'h0000, 1'b0});
`ifdef WB_MASTER_TIMEOUT_EN
        vecs.push_back('{"rd_timeout",   1'b0, 1'b1, 16'h0000, 16'hDEAD, 0, 1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{"rd_term_ack",  1'b0, 1'b0, 16'h0000, 16'hC0DE, 8, 0, 1'b0, 16'hC0DE, 1'b0});
`endif
        vecs.push_back('{"rd_after",     1'b0, 1'b1, 16'h0000, 16'h8001, 3, 1, 1'b0, 16'h8001, 1'b0});

        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_write     = 1'b0;
        cmd_address   = '0;
        cmd_writedata = '0;
        rsp_ready     = 1'b0;
        wbm_readdata  = '0;
        wbm_ack       = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst/cmd_ready", 32'(cmd_ready),     32'd1);
        chk("rst/rsp_valid", 32'(rsp_valid),     32'd0);
        chk("rst/rsp_error", 32'(rsp_error),     32'd0);
        chk("rst/cycle",     32'(wbm_cycle),     32'd0);
        chk("rst/strobe",    32'(wbm_strobe),    32'd0);
        chk("rst/write",     32'(wbm_write),     32'd0);
        chk("rst/busy",      32'(busy),          32'd0);
        chk("rst/rdata",     32'(rsp_readdata),  32'd0);
        chk("rst/addr",      32'(wbm_address),   32'd0);
        chk("rst/wdata",     32'(wbm_writedata), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) do_xfer(vecs[i]);

        // Stray ack in IDLE
        wbm_ack      = 1'b1;
        wbm_readdata = 16'hABCD;
        repeat (2) tick();
        wbm_ack = 1'b0;
        chk("stray/busy",  32'(busy),      32'd0);
        chk("stray/rspv",  32'(rsp_valid), 32'd0);
        chk("stray/cycle", 32'(wbm_cycle), 32'd0);
        chk("stray/ready", 32'(cmd_ready), 32'd1);

        // Reset during BUS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rstbus/in_bus", 32'(wbm_cycle), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstbus/cycle",  32'(wbm_cycle),  32'd0);
        chk("rstbus/strobe", 32'(wbm_strobe), 32'd0);
        chk("rstbus/rspv",   32'(rsp_valid),  32'd0);
        chk("rstbus/ready",  32'(cmd_ready),  32'd1);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        chk("rstbus/late_ack_rspv", 32'(rsp_valid), 32'd0);
        chk("rstbus/late_ack_busy", 32'(busy),      32'd0);

        // Reset and cmd_valid together: reset wins
        reset = 1'b1; cmd_valid = 1'b1;
        tick();
        reset = 1'b0; cmd_valid = 1'b0;
        chk("rstcmd/cycle", 32'(wbm_cycle), 32'd0);
        chk("rstcmd/busy",  32'(busy),      32'd0);

        // One more normal transfer after the resets
        do_xfer(vecs[0]);

        chk("sb/drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "tb_wb_cmd_master stuck");
    end

endmodule
